// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory port, execute redirect inputs
// and the valid/ready channel towards decode.
// The master modport is the fetch controller's view.
// The slave modport is the view of the surrounding memory, execute and decode logic.
interface instr_fetch_ctrl_if;
    logic        fetch_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_fault;

    modport master (
        input  fetch_en,
        output mem_addr,
        input  mem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output fetch_valid,
        input  fetch_ready,
        output fetch_instr,
        output fetch_pc,
        output fetch_fault
    );

    modport slave (
        output fetch_en,
        input  mem_addr,
        output mem_instr,
        output redirect_valid,
        output redirect_pc,
        input  fetch_valid,
        output fetch_ready,
        input  fetch_instr,
        input  fetch_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer.
// Owns the PC and drives a 1-cycle-latency synchronous instruction memory.
// Returned words are buffered in a 2-entry skid FIFO and handed to decode as {pc, instr}.
// Branch/jump redirects flush the buffer and kill any read still in flight.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_WORDS = 32,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_ctrl_if.master    io_bus
);

    // Byte span of the instruction memory; every PC lives in [0, PC_SPAN).
    localparam logic [31:0] PC_SPAN    = 32'(MEM_WORDS * 4);
    // The storage below is built for exactly two entries; the limit is kept symbolic
    // so the issue check reads as "slots promised must stay below the buffer size".
    localparam logic [2:0]  SLOT_LIMIT = 3'(BUF_DEPTH);

    // Program counter: address of the next read to issue.
    logic [31:0] r_pc;

    // Skid buffer, entry 0 is always the head presented to decode.
    logic [31:0] r_buf_pc    [2];
    logic [31:0] r_buf_instr [2];
    logic [1:0]  r_count;

    // Outstanding memory read: its PC and the epoch it was issued in.
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic        r_inflight_epoch;
    logic        r_epoch;

    // Registered misaligned-redirect pulse.
    logic        r_fault;

    logic        w_redirect;
    logic        w_pop;
    logic        w_land;
    logic        w_push;
    logic [2:0]  w_slots_used;
    logic        w_issue;
    logic [31:0] w_pc_seq;
    logic [31:0] w_redirect_target;
    logic        w_misaligned;

    assign w_redirect        = io_bus.redirect_valid;
    assign w_pop             = (r_count != 2'd0) && io_bus.fetch_ready;
    assign w_land            = r_inflight && (r_inflight_epoch == r_epoch);
    assign w_push            = w_land && !w_redirect;

    // Entries that will be occupied once this edge's pop and landing are applied.
    // Counting the pop lets a new read issue in the same cycle decode drains
    // the head, which is what sustains one instruction per cycle.
    assign w_slots_used      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue           = io_bus.fetch_en && !w_redirect && (w_slots_used < SLOT_LIMIT);

    assign w_pc_seq          = (r_pc + 32'd4) % PC_SPAN;
    assign w_redirect_target = {io_bus.redirect_pc[31:2], 2'b00} % PC_SPAN;
    assign w_misaligned      = |io_bus.redirect_pc[1:0];

    assign io_bus.mem_addr    = r_pc;
    assign io_bus.fetch_valid = (r_count != 2'd0);
    assign io_bus.fetch_instr = r_buf_instr[0];
    assign io_bus.fetch_pc    = r_buf_pc[0];
    assign io_bus.fetch_fault = r_fault;

    // PC update: a redirect overrides everything; otherwise advance only on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_redirect_target;
        end else if (w_issue) begin
            r_pc <= w_pc_seq;
        end
    end

    // In-flight tracking: a redirect bumps the epoch so any returning stale word is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight       <= 1'b0;
            r_inflight_pc    <= 32'd0;
            r_inflight_epoch <= 1'b0;
            r_epoch          <= 1'b0;
        end else if (w_redirect) begin
            r_inflight <= 1'b0;
            r_epoch    <= ~r_epoch;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc    <= r_pc;
                r_inflight_epoch <= r_epoch;
            end
        end
    end

    // Skid buffer: push the landing word, pop on handshake, flush on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count        <= 2'd0;
            r_buf_pc[0]    <= 32'd0;
            r_buf_pc[1]    <= 32'd0;
            r_buf_instr[0] <= 32'd0;
            r_buf_instr[1] <= 32'd0;
        end else if (w_redirect) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf_pc[0]    <= r_inflight_pc;
                        r_buf_instr[0] <= io_bus.mem_instr;
                    end else begin
                        r_buf_pc[1]    <= r_inflight_pc;
                        r_buf_instr[1] <= io_bus.mem_instr;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf_pc[0]    <= r_buf_pc[1];
                    r_buf_instr[0] <= r_buf_instr[1];
                    r_count        <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf_pc[0]    <= r_inflight_pc;
                        r_buf_instr[0] <= io_bus.mem_instr;
                    end else begin
                        r_buf_pc[0]    <= r_buf_pc[1];
                        r_buf_instr[0] <= r_buf_instr[1];
                        r_buf_pc[1]    <= r_inflight_pc;
                        r_buf_instr[1] <= io_bus.mem_instr;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // Fault pulse: one cycle after a redirect whose target was not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_redirect && w_misaligned;
        end
    end

    // Guard: the issue rule must never let a landing word find the buffer full.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && !w_pop && (r_count == 2'd2)));
        end
    end

endmodule
